imem_fetch_arbiter: RTL and testbench

//  Shares the single instruction-memory bus between demand fetch (Icache miss) and the prefetcher.

---
 rtl/imem_fetch_arbiter_pkg.sv | 21 ++
 rtl/imem_outst_table.sv | 87 ++++++++
 rtl/imem_fetch_arbiter.sv | 146 ++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types for the instruction-memory fetch arbiter.
// Bus command encoding matches the memory model.
package imem_fetch_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    localparam int IMEM_TAG_W  = 4;
    localparam int IMEM_LINE_W = 61;

    typedef struct packed {
        logic                   valid;
        logic [IMEM_LINE_W-1:0] addr;
        logic                   own_dmd;
        logic                   own_pref;
    } imem_outst_entry_t;

endpackage

// File: rtl/imem_outst_table.sv
// Tag-indexed table of loads in flight: address match,
// allocate on accepted load, free on returning block.
module imem_outst_table
    import imem_fetch_arbiter_pkg::*;
#(
    parameter int NUM_TAGS  = 15,
    parameter int MAX_OUTST = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [IMEM_LINE_W-1:0] dmd_line,
    input  logic [IMEM_LINE_W-1:0] pref_line,
    output logic                   dmd_hit,
    output logic                   pref_hit,
    input  logic                   merge_dmd,
    input  logic                   merge_pref,
    input  logic                   alloc_en,
    input  logic [IMEM_TAG_W-1:0]  alloc_tag,
    input  logic [IMEM_LINE_W-1:0] alloc_line,
    input  logic                   alloc_dmd,
    input  logic                   alloc_pref,
    input  logic [IMEM_TAG_W-1:0]  fill_tag,
    output logic                   fill_hit,
    output imem_outst_entry_t      fill_entry,
    output logic                   full
);

    localparam int CNT_W = $clog2(NUM_TAGS + 1);

    imem_outst_entry_t     tbl [0:NUM_TAGS];
    logic [CNT_W-1:0]      count;
    logic [IMEM_TAG_W-1:0] dmd_tag;
    logic [IMEM_TAG_W-1:0] pref_tag;
    logic                  inc;

    always_comb begin
        dmd_hit  = 1'b0;
        pref_hit = 1'b0;
        dmd_tag  = '0;
        pref_tag = '0;
        for (int t = 1; t <= NUM_TAGS; t++) begin
            if (!dmd_hit && tbl[t].valid && tbl[t].addr == dmd_line) begin
                dmd_hit = 1'b1;
                dmd_tag = IMEM_TAG_W'(t);
            end
            if (!pref_hit && tbl[t].valid && tbl[t].addr == pref_line) begin
                pref_hit = 1'b1;
                pref_tag = IMEM_TAG_W'(t);
            end
        end
    end

    assign fill_entry = tbl[fill_tag];
    assign fill_hit   = (fill_tag != '0) && fill_entry.valid;
    assign full       = (count >= CNT_W'(MAX_OUTST));

    // A tag freed this cycle may be reallocated at once; net count is then unchanged.
    assign inc = alloc_en &&
                 (!tbl[alloc_tag].valid || (fill_hit && fill_tag == alloc_tag));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t <= NUM_TAGS; t++) begin
                tbl[t] <= '0;
            end
            count <= '0;
        end else begin
            if (fill_hit) begin
                tbl[fill_tag] <= '0;
            end
            if (merge_dmd) begin
                tbl[dmd_tag].own_dmd <= 1'b1;
            end
            if (merge_pref) begin
                tbl[pref_tag].own_pref <= 1'b1;
            end
            if (alloc_en) begin
                tbl[alloc_tag] <= '{valid:    1'b1,
                                   addr:     alloc_line,
                                   own_dmd:  alloc_dmd,
                                   own_pref: alloc_pref};
            end
            count <= count + CNT_W'(inc) - CNT_W'(fill_hit);
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares the instruction-memory bus between demand fetch and prefetch,
// tracks loads in flight by tag and routes returning blocks to owners.
module imem_fetch_arbiter
    import imem_fetch_arbiter_pkg::*;
#(
    parameter int NUM_TAGS     = 15,
    parameter int MAX_OUTST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dmd_req_valid,
    input  logic [63:0]           dmd_req_addr,
    output logic                  dmd_req_grant,
    input  logic                  pref_req_valid,
    input  logic [63:0]           pref_req_addr,
    output logic                  pref_req_grant,
    output BUS_COMMAND            proc2Imem_command,
    output logic [63:0]           proc2Imem_addr,
    input  logic [IMEM_TAG_W-1:0] Imem2proc_response,
    input  logic [IMEM_TAG_W-1:0] Imem2proc_tag,
    input  logic [63:0]           Imem2proc_data,
    output logic                  dmd_fill_valid,
    output logic                  pref_fill_valid,
    output logic [63:0]           fill_addr,
    output logic [63:0]           fill_data,
    output logic                  outst_full
);

    localparam int ST_W = $clog2(STARVE_LIMIT + 1);

    logic [IMEM_LINE_W-1:0] dmd_line;
    logic [IMEM_LINE_W-1:0] pref_line;
    logic [IMEM_LINE_W-1:0] win_line;
    logic                   dmd_hit;
    logic                   pref_hit;
    logic                   merge_dmd;
    logic                   merge_pref;
    logic                   alloc_en;
    logic                   alloc_dmd;
    logic                   alloc_pref;
    logic                   fill_hit;
    imem_outst_entry_t      fill_entry;
    logic [ST_W-1:0]        starve;
    logic                   pref_first;
    logic                   dmd_win;
    logic                   pref_win;
    logic                   share_dmd;
    logic                   share_pref;
    logic                   unused_low_bits;

    assign dmd_line        = dmd_req_addr[63:3];
    assign pref_line       = pref_req_addr[63:3];
    assign unused_low_bits = ^{dmd_req_addr[2:0], pref_req_addr[2:0]};
    assign pref_first      = pref_req_valid && (starve == ST_W'(STARVE_LIMIT));

    imem_outst_table #(
        .NUM_TAGS  (NUM_TAGS),
        .MAX_OUTST (MAX_OUTST)
    ) u_table (
        .clock      (clock),
        .reset      (reset),
        .dmd_line   (dmd_line),
        .pref_line  (pref_line),
        .dmd_hit    (dmd_hit),
        .pref_hit   (pref_hit),
        .merge_dmd  (merge_dmd),
        .merge_pref (merge_pref),
        .alloc_en   (alloc_en),
        .alloc_tag  (Imem2proc_response),
        .alloc_line (win_line),
        .alloc_dmd  (alloc_dmd),
        .alloc_pref (alloc_pref),
        .fill_tag   (Imem2proc_tag),
        .fill_hit   (fill_hit),
        .fill_entry (fill_entry),
        .full       (outst_full)
    );

    always_comb begin
        proc2Imem_command = BUS_NONE;
        proc2Imem_addr    = '0;
        dmd_req_grant     = 1'b0;
        pref_req_grant    = 1'b0;
        merge_dmd         = 1'b0;
        merge_pref        = 1'b0;
        alloc_en          = 1'b0;
        alloc_dmd         = 1'b0;
        alloc_pref        = 1'b0;
        dmd_win           = dmd_req_valid && !pref_first;
        pref_win          = pref_req_valid && !dmd_win;
        win_line          = dmd_win ? dmd_line : pref_line;
        share_dmd         = dmd_req_valid && !dmd_hit && dmd_line == win_line;
        share_pref        = pref_req_valid && !pref_hit && pref_line == win_line;
        if (!reset && !outst_full) begin
            // Merges cost no bus slot, so either requester may merge.
            if (dmd_req_valid && dmd_hit) begin
                merge_dmd     = 1'b1;
                dmd_req_grant = 1'b1;
            end
            if (pref_req_valid && pref_hit) begin
                merge_pref     = 1'b1;
                pref_req_grant = 1'b1;
            end
            if ((dmd_win && !dmd_hit) || (pref_win && !pref_hit)) begin
                proc2Imem_command = BUS_LOAD;
                proc2Imem_addr    = {win_line, 3'b000};
                if (Imem2proc_response != '0) begin
                    alloc_en   = 1'b1;
                    alloc_dmd  = share_dmd;
                    alloc_pref = share_pref;
                    if (share_dmd) begin
                        dmd_req_grant = 1'b1;
                    end
                    if (share_pref) begin
                        pref_req_grant = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        dmd_fill_valid  = 1'b0;
        pref_fill_valid = 1'b0;
        fill_addr       = '0;
        fill_data       = '0;
        if (fill_hit) begin
            dmd_fill_valid  = fill_entry.own_dmd;
            pref_fill_valid = fill_entry.own_pref;
            fill_addr       = {fill_entry.addr, 3'b000};
            fill_data       = Imem2proc_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve <= '0;
        end else if (!pref_req_valid || pref_req_grant) begin
            starve <= '0;
        end else if (starve != ST_W'(STARVE_LIMIT)) begin
            starve <= starve + ST_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed-vector bench for the fetch arbiter.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_imem_fetch_arbiter;
    import imem_fetch_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        dmd_req_valid;
    logic [63:0] dmd_req_addr;
    logic        dmd_req_grant;
    logic        pref_req_valid;
    logic [63:0] pref_req_addr;
    logic        pref_req_grant;
    BUS_COMMAND  proc2Imem_command;
    logic [63:0] proc2Imem_addr;
    logic [3:0]  Imem2proc_response;
    logic [3:0]  Imem2proc_tag;
    logic [63:0] Imem2proc_data;
    logic        dmd_fill_valid;
    logic        pref_fill_valid;
    logic [63:0] fill_addr;
    logic [63:0] fill_data;
    logic        outst_full;

    int n_checks = 0;
    int n_fail   = 0;

    imem_fetch_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .dmd_req_valid      (dmd_req_valid),
        .dmd_req_addr       (dmd_req_addr),
        .dmd_req_grant      (dmd_req_grant),
        .pref_req_valid     (pref_req_valid),
        .pref_req_addr      (pref_req_addr),
        .pref_req_grant     (pref_req_grant),
        .proc2Imem_command  (proc2Imem_command),
        .proc2Imem_addr     (proc2Imem_addr),
        .Imem2proc_response (Imem2proc_response),
        .Imem2proc_tag      (Imem2proc_tag),
        .Imem2proc_data     (Imem2proc_data),
        .dmd_fill_valid     (dmd_fill_valid),
        .pref_fill_valid    (pref_fill_valid),
        .fill_addr          (fill_addr),
        .fill_data          (fill_data),
        .outst_full         (outst_full)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic expect_eq(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [63:0] da,
                         input logic pv, input logic [63:0] pa,
                         input logic [3:0] resp, input logic [3:0] tg,
                         input logic [63:0] dat);
        dmd_req_valid      = dv;
        dmd_req_addr       = da;
        pref_req_valid     = pv;
        pref_req_addr      = pa;
        Imem2proc_response = resp;
        Imem2proc_tag      = tg;
        Imem2proc_data     = dat;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 64'h1004, 0, 0, 4'd3, 4'd3, 64'h55);
        expect_eq("rst_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
        expect_eq("rst_addr", proc2Imem_addr, 0);
        expect_eq("rst_grant", 64'(dmd_req_grant), 0);
        expect_eq("rst_fill", 64'(dmd_fill_valid), 0);
        tick();
        tick();
        reset = 1'b0;
        idle();
        expect_eq("rst_full", 64'(outst_full), 0);

        // basic demand load and fill
        drive(1, 64'h1004, 0, 0, 4'd3, 0, 0);
        expect_eq("ld_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
        expect_eq("ld_addr", proc2Imem_addr, 64'h1000);
        expect_eq("ld_grant", 64'(dmd_req_grant), 1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd3, 64'hdeadbeef);
        expect_eq("fill_dv", 64'(dmd_fill_valid), 1);
        expect_eq("fill_pv", 64'(pref_fill_valid), 0);
        expect_eq("fill_addr", fill_addr, 64'h1000);
        expect_eq("fill_data", fill_data, 64'hdeadbeef);
        tick();
        drive(0, 0, 0, 0, 0, 4'd3, 64'h1);
        expect_eq("stray_dv", 64'(dmd_fill_valid), 0);
        tick();

        // rejected load is retried with the same address
        drive(1, 64'h1100, 0, 0, 4'd0, 0, 0);
        expect_eq("rej_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
        expect_eq("rej_grant", 64'(dmd_req_grant), 0);
        tick();
        drive(1, 64'h1100, 0, 0, 4'd7, 0, 0);
        expect_eq("retry_addr", proc2Imem_addr, 64'h1100);
        expect_eq("retry_grant", 64'(dmd_req_grant), 1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd7, 0);
        tick();

        // prefetch starvation
        for (int i = 0; i < 5; i++) begin
            drive(1, 64'h3000 + 64'(i) * 64'h40, 1, 64'h5000, 4'd5, 0, 0);
            if (i < 4) begin
                expect_eq("stv_addr", proc2Imem_addr, 64'h3000 + 64'(i) * 64'h40);
                expect_eq("stv_dg", 64'(dmd_req_grant), 1);
                expect_eq("stv_pg", 64'(pref_req_grant), 0);
            end else begin
                expect_eq("stv_paddr", proc2Imem_addr, 64'h5000);
                expect_eq("stv_pg5", 64'(pref_req_grant), 1);
                expect_eq("stv_dg5", 64'(dmd_req_grant), 0);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 4'd5, 64'h77);
        expect_eq("stv_fpv", 64'(pref_fill_valid), 1);
        expect_eq("stv_fdv", 64'(dmd_fill_valid), 0);
        expect_eq("stv_faddr", fill_addr, 64'h5000);
        tick();

        // prefetch merges into in-flight demand load
        drive(1, 64'h2000, 0, 0, 4'd2, 0, 0);
        expect_eq("mrg_dg", 64'(dmd_req_grant), 1);
        tick();
        drive(0, 0, 1, 64'h2004, 4'd9, 0, 0);
        expect_eq("mrg_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
        expect_eq("mrg_pg", 64'(pref_req_grant), 1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd2, 64'h22);
        expect_eq("mrg_fdv", 64'(dmd_fill_valid), 1);
        expect_eq("mrg_fpv", 64'(pref_fill_valid), 1);
        expect_eq("mrg_faddr", fill_addr, 64'h2000);
        tick();

        // both requesters, same block, no entry yet
        drive(1, 64'h6000, 1, 64'h6000, 4'd6, 0, 0);
        expect_eq("same_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
        expect_eq("same_dg", 64'(dmd_req_grant), 1);
        expect_eq("same_pg", 64'(pref_req_grant), 1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd6, 64'h66);
        expect_eq("same_fdv", 64'(dmd_fill_valid), 1);
        expect_eq("same_fpv", 64'(pref_fill_valid), 1);
        tick();

        // fill the table
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'h8000 + 64'(i) * 64'h100, 0, 0, 4'(i + 1), 0, 0);
            expect_eq("fill8_grant", 64'(dmd_req_grant), 1);
            tick();
        end
        idle();
        expect_eq("full_set", 64'(outst_full), 1);
        drive(1, 64'h9000, 0, 0, 4'd9, 4'd1, 64'h11);
        expect_eq("full_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
        expect_eq("full_grant", 64'(dmd_req_grant), 0);
        expect_eq("full_fill", 64'(dmd_fill_valid), 1);
        expect_eq("full_faddr", fill_addr, 64'h8000);
        tick();
        drive(1, 64'h9000, 0, 0, 4'd9, 0, 0);
        expect_eq("resume_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
        expect_eq("resume_addr", proc2Imem_addr, 64'h9000);
        expect_eq("resume_grant", 64'(dmd_req_grant), 1);
        tick();
        idle();
        expect_eq("full_again", 64'(outst_full), 1);

        // fill and reallocate the same tag in one cycle
        drive(0, 0, 0, 0, 0, 4'd2, 0);
        tick();
        drive(1, 64'hA000, 0, 0, 4'd3, 4'd3, 64'h33);
        expect_eq("same_tag_grant", 64'(dmd_req_grant), 1);
        expect_eq("same_tag_faddr", fill_addr, 64'h8200);
        tick();
        idle();
        expect_eq("net_full", 64'(outst_full), 0);
        drive(0, 0, 0, 0, 0, 4'd3, 64'h34);
        expect_eq("realloc_faddr", fill_addr, 64'hA000);
        expect_eq("realloc_fdv", 64'(dmd_fill_valid), 1);
        tick();
        drive(1, 64'hB000, 0, 0, 4'd10, 0, 0);
        tick();
        idle();
        expect_eq("seven_full", 64'(outst_full), 0);
        drive(1, 64'hB100, 0, 0, 4'd11, 0, 0);
        tick();
        idle();
        expect_eq("eight_full", 64'(outst_full), 1);

        // reset while loads are in flight
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 4'd4, 64'h44);
        expect_eq("post_rst_dv", 64'(dmd_fill_valid), 0);
        expect_eq("post_rst_pv", 64'(pref_fill_valid), 0);
        expect_eq("post_rst_full", 64'(outst_full), 0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1, 64'hC000 + 64'(i) * 64'h100, 0, 0, 4'(i + 1), 0, 0);
            tick();
        end
        idle();
        expect_eq("cnt_zero_7", 64'(outst_full), 0);
        drive(1, 64'hC800, 0, 0, 4'd8, 0, 0);
        tick();
        idle();
        expect_eq("cnt_zero_8", 64'(outst_full), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
